// File: rtl/or1k_wb_ext_slave_mem.sv
// Wishbone B3 slave memory for the OR1K tile external bus window.
// Classic, constant-address and incrementing (linear/wrap) bursts, with
// optional wait states ahead of the first response of each bus cycle.
module or1k_wb_ext_slave_mem #(
  parameter int unsigned    AW          = 32,
  parameter int unsigned    DW          = 32,
  parameter int unsigned    MEM_AW      = 10,
  parameter logic [AW-1:0]  BASE_ADDR   = '0,
  parameter int unsigned    WAIT_STATES = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] wb_adr_i,
  input  logic          wb_cyc_i,
  input  logic [DW-1:0] wb_dat_i,
  input  logic [3:0]    wb_sel_i,
  input  logic          wb_stb_i,
  input  logic          wb_we_i,
  input  logic          wb_cab_i,
  input  logic [2:0]    wb_cti_i,
  input  logic [1:0]    wb_bte_i,
  output logic          wb_ack_o,
  output logic          wb_rty_o,
  output logic          wb_err_o,
  output logic [DW-1:0] wb_dat_o
);

  localparam int unsigned   DEPTH = 2 ** MEM_AW;
  localparam logic [AW:0]   SPAN  = (AW+1)'(DEPTH) << 2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t              state_reg, state_next;
  logic [MEM_AW-1:0]   idx_reg, idx_next, rd_idx;
  logic                we_reg, we_next;
  logic [1:0]          bte_reg, bte_next;
  logic                err_reg, err_next;
  logic [3:0]          cnt_reg, cnt_next;
  logic [DW-1:0]       mem [DEPTH];
  logic [DW-1:0]       rd_reg;

  logic [AW:0]         off_ext;
  logic                in_range;
  logic [MEM_AW-1:0]   dec_idx;
  logic                req, beat, is_burst;
  logic [MEM_AW:0]     idx_inc;
  logic [MEM_AW-1:0]   wrap_mask, wrap_idx;
  logic                unused;

  // Address decode: the extra top bit makes addresses below the base wrap
  // to huge offsets, so one compare covers both range limits.
  assign off_ext  = {1'b0, wb_adr_i} - {1'b0, BASE_ADDR};
  assign in_range = (off_ext < SPAN) && (wb_adr_i[1:0] == 2'b00);
  assign dec_idx  = off_ext[MEM_AW+1:2];

  assign req      = wb_cyc_i & wb_stb_i;
  assign beat     = (state_reg == S_RESP) & req;
  assign is_burst = (wb_cti_i == 3'b001) || (wb_cti_i == 3'b010);

  // Responses are qualified by the live strobe so a withdrawn beat is never acked.
  assign wb_ack_o = beat & ~err_reg;
  assign wb_err_o = beat & err_reg;
  assign wb_rty_o = 1'b0;
  assign wb_dat_o = wb_ack_o ? rd_reg : '0;

  // The legacy burst hint carries no information beyond cti.
  assign unused   = wb_cab_i;

  // Address stepping for incrementing bursts; carry out of idx_inc marks the end of memory.
  assign idx_inc  = {1'b0, idx_reg} + (MEM_AW+1)'(1);
  assign wrap_idx = (idx_reg & ~wrap_mask) | (idx_inc[MEM_AW-1:0] & wrap_mask);

  // Wrap boundary mask selected by the burst type latched at cycle start.
  always_comb begin
    wrap_mask = '0;
    case (bte_reg)
      2'b01:   wrap_mask = MEM_AW'(3);
      2'b10:   wrap_mask = MEM_AW'(7);
      2'b11:   wrap_mask = MEM_AW'(15);
      default: wrap_mask = '0;
    endcase
  end

  // Next-state logic; rd_idx selects the word presented on the following response cycle.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    we_next    = we_reg;
    bte_next   = bte_reg;
    err_next   = err_reg;
    cnt_next   = cnt_reg;
    rd_idx     = idx_reg;
    case (state_reg)
      S_IDLE: begin
        if (req) begin
          idx_next   = dec_idx;
          we_next    = wb_we_i;
          bte_next   = wb_bte_i;
          err_next   = !in_range;
          cnt_next   = '0;
          rd_idx     = dec_idx;
          state_next = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        if (!req)
          state_next = S_IDLE;
        else if (cnt_reg == 4'(WAIT_STATES - 1))
          state_next = S_RESP;
        else
          cnt_next = cnt_reg + 4'd1;
      end
      S_RESP: begin
        if (!req || err_reg || !is_burst) begin
          state_next = S_IDLE;
        end else if (wb_cti_i == 3'b010) begin
          if (bte_reg == 2'b00) begin
            idx_next = idx_inc[MEM_AW-1:0];
            err_next = idx_inc[MEM_AW];
          end else begin
            idx_next = wrap_idx;
          end
          rd_idx = idx_next;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      idx_reg   <= '0;
      we_reg    <= 1'b0;
      bte_reg   <= 2'b00;
      err_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      we_reg    <= we_next;
      bte_reg   <= bte_next;
      err_reg   <= err_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Memory array: byte-lane writes on acked write beats, registered read port; contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst && wb_ack_o && we_reg) begin
      for (int i = 0; i < 4; i++) begin
        if (wb_sel_i[i])
          mem[idx_reg][8*i +: 8] <= wb_dat_i[8*i +: 8];
      end
    end
    rd_reg <= mem[rd_idx];
  end

endmodule

// File: tb/tb_or1k_wb_ext_slave_mem.sv
// Bench for or1k_wb_ext_slave_mem: two instances (no wait states at base 0,
// three wait states at base 0x1000), a transaction-level memory model that
// sets per-cycle expectations, and one negedge compare process.
module tb_or1k_wb_ext_slave_mem;

  localparam logic [31:0] BASE1 = 32'h1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] adr = '0, dat_i = '0;
  logic [3:0]  sel = '0;
  logic        we = 1'b0, cab = 1'b0;
  logic [2:0]  cti = '0;
  logic [1:0]  bte = '0;
  logic [1:0]  cyc = '0, stb = '0;
  logic        ack0, ack1, err0, err1, rty0, rty1;
  logic [31:0] dat0, dat1;

  always #5 clk = ~clk;

  or1k_wb_ext_slave_mem #(.AW(32), .DW(32), .MEM_AW(4), .BASE_ADDR(32'h0), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .wb_adr_i(adr), .wb_cyc_i(cyc[0]), .wb_dat_i(dat_i), .wb_sel_i(sel),
    .wb_stb_i(stb[0]), .wb_we_i(we), .wb_cab_i(cab), .wb_cti_i(cti), .wb_bte_i(bte),
    .wb_ack_o(ack0), .wb_rty_o(rty0), .wb_err_o(err0), .wb_dat_o(dat0));

  or1k_wb_ext_slave_mem #(.AW(32), .DW(32), .MEM_AW(4), .BASE_ADDR(BASE1), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst(rst), .wb_adr_i(adr), .wb_cyc_i(cyc[1]), .wb_dat_i(dat_i), .wb_sel_i(sel),
    .wb_stb_i(stb[1]), .wb_we_i(we), .wb_cab_i(cab), .wb_cti_i(cti), .wb_bte_i(bte),
    .wb_ack_o(ack1), .wb_rty_o(rty1), .wb_err_o(err1), .wb_dat_o(dat1));

  // Model state and expectations
  logic [31:0] mmem [2][16];
  int          ws_of [2]   = '{0, 3};
  logic [31:0] base_of [2] = '{32'h0, BASE1};
  logic [1:0]  exp_ack = '0, exp_err = '0, exp_dchk = '0;
  logic [31:0] exp_dat [2] = '{32'h0, 32'h0};
  int          checks = 0, passes = 0;
  int          cyc_cnt = 0, t_start = 0, first_ack = -1, n_ack = 0, n_err = 0;
  logic [31:0] cap_q [$];
  logic [31:0] bd [16];
  logic [3:0]  bs [16];
  logic        chk_on = 1'b0;

  task automatic chk(string name, logic [31:0] got, logic [31:0] expv);
    checks++;
    if (got === expv) passes++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, expv, $time);
  endtask

  function automatic logic [31:0] capn(int i);
    return (cap_q.size() > i) ? cap_q[i] : 32'hBAD0BAD0;
  endfunction

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // One compare process: every cycle, every output of both instances.
  always @(negedge clk) begin
    if (chk_on) begin
      for (int d = 0; d < 2; d++) begin
        logic        a, e, r;
        logic [31:0] dv;
        a  = (d == 0) ? ack0 : ack1;
        e  = (d == 0) ? err0 : err1;
        r  = (d == 0) ? rty0 : rty1;
        dv = (d == 0) ? dat0 : dat1;
        chk($sformatf("ack_dut%0d", d), {31'b0, a}, {31'b0, exp_ack[d]});
        chk($sformatf("err_dut%0d", d), {31'b0, e}, {31'b0, exp_err[d]});
        chk($sformatf("rty_dut%0d", d), {31'b0, r}, 32'h0);
        if (exp_ack[d] && exp_dchk[d]) chk($sformatf("rdata_dut%0d", d), dv, exp_dat[d]);
        else if (!exp_ack[d]) chk($sformatf("dat_idle_dut%0d", d), dv, 32'h0);
        if (a) begin
          n_ack++;
          cap_q.push_back(dv);
          if (first_ack < 0) first_ack = cyc_cnt;
        end
        if (e) n_err++;
      end
    end
  end

  task automatic present(int k, int n, logic [2:0] bc);
    dat_i = bd[k];
    sel   = bs[k];
    cti   = (bc == 3'b000) ? 3'b000 : ((k == n - 1) ? 3'b111 : bc);
  endtask

  // One bus cycle on instance d. Expected responses come from the model:
  // range check, WAIT_STATES+1 quiet cycles, then one response per beat.
  task automatic run(int d, logic [31:0] a, bit w, int n, logic [2:0] bc, logic [1:0] bt, int drop);
    bit ok, done;
    int idx, k, nw;
    ok  = (a >= base_of[d]) && (a < base_of[d] + 32'd64) && (a[1:0] == 2'b00);
    idx = ok ? int'((a - base_of[d]) >> 2) : 0;
    n_ack = 0; n_err = 0; cap_q.delete(); first_ack = -1; t_start = cyc_cnt;
    adr = a; we = w; bte = bt; cab = 1'($urandom_range(0, 1));
    cyc[d] = 1'b1; stb[d] = 1'b1;
    present(0, n, bc);
    repeat (1 + ws_of[d]) begin @(posedge clk); #1; end
    k = 0; done = 0;
    while (!done) begin
      if (k == drop) begin
        stb[d] = 1'b0;
        @(posedge clk); #1;
        done = 1;
      end else begin
        if (!ok) exp_err[d] = 1'b1;
        else begin
          exp_ack[d]  = 1'b1;
          exp_dat[d]  = mmem[d][idx];
          exp_dchk[d] = !w;
        end
        @(posedge clk); #1;
        exp_ack[d] = 1'b0; exp_err[d] = 1'b0; exp_dchk[d] = 1'b0;
        if (!ok) done = 1;
        else begin
          if (w) for (int b = 0; b < 4; b++) if (bs[k][b]) mmem[d][idx][8*b +: 8] = bd[k][8*b +: 8];
          if (cti != 3'b001 && cti != 3'b010) done = 1;
          else begin
            if (cti == 3'b010) begin
              if (bt == 2'b00) begin
                if (idx == 15) ok = 0;
                else idx++;
              end else begin
                nw  = 4 << (bt - 1);
                idx = (idx & ~(nw - 1)) | ((idx + 1) & (nw - 1));
              end
            end
            k++;
            adr = adr + 32'd4;
            present(k, n, bc);
          end
        end
      end
    end
    cyc[d] = 1'b0; stb[d] = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int d, kind, n, drop;
    logic [31:0] a;
    logic [1:0]  bt;
    logic [2:0]  bc;
    bit          w;

    @(posedge clk); #1; chk_on = 1'b1;
    @(posedge clk); #1; rst = 1'b0;

    // Fill both memories with a 16-beat linear write burst
    for (int dd = 0; dd < 2; dd++) begin
      for (int i = 0; i < 16; i++) begin bd[i] = $urandom; bs[i] = 4'hF; end
      run(dd, base_of[dd], 1, 16, 3'b010, 2'b00, -1);
    end

    // T1: word 0 survives a 3-cycle reset
    bd[0] = 32'h0000_1234; bs[0] = 4'hF;
    run(0, 32'h0, 1, 1, 3'b000, 2'b00, -1);
    rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b0;
    run(0, 32'h0, 0, 1, 3'b000, 2'b00, -1);
    chk("T1_word0_after_reset", capn(0), 32'h0000_1234);

    // T2: classic write/read, one-cycle latency
    bd[0] = 32'hDEAD_BEEF; bs[0] = 4'hF;
    run(0, 32'h10, 1, 1, 3'b000, 2'b00, -1);
    chk("T2_write_latency", 32'(first_ack - t_start), 32'd1);
    run(0, 32'h10, 0, 1, 3'b000, 2'b00, -1);
    chk("T2_read_0x10", capn(0), 32'hDEAD_BEEF);

    // T3: single byte-lane write
    bd[0] = 32'h0000_AB00; bs[0] = 4'b0010;
    run(0, 32'h10, 1, 1, 3'b000, 2'b00, -1);
    chk("T3_model_word4", mmem[0][4], 32'hDEAD_ABEF);
    run(0, 32'h10, 0, 1, 3'b000, 2'b00, -1);
    chk("T3_read_0x10", capn(0), 32'hDEAD_ABEF);

    // T4: wrap4 read from 0x0C
    for (int i = 0; i < 4; i++) begin bd[i] = 32'hA0 + i; bs[i] = 4'hF; end
    run(0, 32'h0, 1, 4, 3'b010, 2'b00, -1);
    run(0, 32'h0C, 0, 4, 3'b010, 2'b01, -1);
    chk("T4_ack_count", n_ack, 4);
    chk("T4_beat0", capn(0), 32'hA3);
    chk("T4_beat1", capn(1), 32'hA0);
    chk("T4_beat2", capn(2), 32'hA1);
    chk("T4_beat3", capn(3), 32'hA2);

    // T5: out-of-range read and misaligned write
    run(0, 32'h40, 0, 1, 3'b000, 2'b00, -1);
    chk("T5_oor_err_count", n_err, 1);
    chk("T5_oor_ack_count", n_ack, 0);
    bd[0] = 32'hFFFF_FFFF; bs[0] = 4'hF;
    run(0, 32'h02, 1, 1, 3'b000, 2'b00, -1);
    chk("T5_misaligned_err_count", n_err, 1);
    run(0, 32'h00, 0, 1, 3'b000, 2'b00, -1);
    chk("T5_word0_unchanged", capn(0), 32'hA0);

    // T6: three wait states; burst abandoned after two beats
    run(1, BASE1, 0, 1, 3'b000, 2'b00, -1);
    chk("T6_read_latency", 32'(first_ack - t_start), 32'd4);
    bd[0] = 32'h55AA_55AA; bs[0] = 4'hF;
    run(1, BASE1 + 32'h28, 1, 1, 3'b000, 2'b00, -1);
    bd[0] = 32'h1111_0000; bd[1] = 32'h1111_2222; bd[2] = 32'h3333_4444; bd[3] = 32'h5555_6666;
    for (int i = 0; i < 4; i++) bs[i] = 4'hF;
    run(1, BASE1 + 32'h20, 1, 4, 3'b010, 2'b00, 2);
    chk("T6_burst_ack_count", n_ack, 2);
    run(1, BASE1 + 32'h28, 0, 1, 3'b000, 2'b00, -1);
    chk("T6_beat3_not_written", capn(0), 32'h55AA_55AA);
    run(1, BASE1 + 32'h24, 0, 1, 3'b000, 2'b00, -1);
    chk("T6_beat2_written", capn(0), 32'h1111_2222);

    // Linear burst running off the end of memory
    run(0, 32'h38, 0, 4, 3'b010, 2'b00, -1);
    chk("end_of_mem_ack_count", n_ack, 2);
    chk("end_of_mem_err_count", n_err, 1);

    // Randomized traffic against the model
    for (int t = 0; t < 120; t++) begin
      d    = $urandom_range(0, 1);
      kind = $urandom_range(0, 3);
      a    = base_of[d] + (32'($urandom_range(0, 17)) << 2);
      if ($urandom_range(0, 9) == 0) a = a + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 14) == 0) a = base_of[d] - 32'd4;
      n    = (kind == 0) ? 1 : $urandom_range(1, 8);
      bc   = (kind == 0) ? 3'b000 : ((kind == 1) ? 3'b001 : 3'b010);
      bt   = (kind == 3) ? 2'($urandom_range(1, 3)) : 2'b00;
      drop = ($urandom_range(0, 5) == 0) ? $urandom_range(0, n - 1) : -1;
      w    = 1'($urandom_range(0, 1));
      for (int i = 0; i < 16; i++) begin bd[i] = $urandom; bs[i] = 4'($urandom); end
      run(d, a, w, n, bc, bt, drop);
    end

    // Full read-back of both memories
    for (int dd = 0; dd < 2; dd++) run(dd, base_of[dd], 0, 16, 3'b010, 2'b00, -1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
